apb_pwm_capture: RTL and testbench

APB slave input-capture block that measures an external PWM waveform. It is the receive-side counterpart of the PWM generator.
- Synchronises `pwm_in` to `apb_pclk`.
- Measures period and high time in pclk cycles between consecutive rising edges.
- Publishes each coherent period/high pair through APB-readable registers and raises an interrupt.
- Used for loop-back test of the generator and for external tachometer/duty inputs.

---
 rtl/apb_pwm_capture_pkg.sv | 20 ++
 rtl/apb_pwm_capture_edge_sync.sv | 31 +++
 rtl/apb_pwm_capture.sv | 165 ++++++++++++++++
 tb/tb_apb_pwm_capture.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pwm_capture_pkg.sv
// rtl/apb_pwm_capture_pkg.sv - shared types and constants for the PWM capture block
package apb_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } cap_state_e;

    localparam int unsigned OFF_CTRL   = 32'h0;
    localparam int unsigned OFF_STAT   = 32'h4;
    localparam int unsigned OFF_PERIOD = 32'h8;
    localparam int unsigned OFF_HIGH   = 32'hC;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STAT_VALID  = 0;
    localparam int STAT_OVF    = 1;

endpackage

// File: rtl/apb_pwm_capture_edge_sync.sv
// rtl/apb_pwm_capture_edge_sync.sv - 2FF synchroniser with single-cycle rise/fall detect
module pwm_edge_sync (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic in_i,
    output logic rise_o,
    output logic fall_o,
    output logic level_o
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign rise_o  = sync2_q & ~dly_q;
    assign fall_o  = ~sync2_q & dly_q;
    assign level_o = sync2_q;

endmodule

// File: rtl/apb_pwm_capture.sv
// rtl/apb_pwm_capture.sv - APB input-capture block measuring PWM period and high time
module apb_pwm_capture
    import apb_pwm_pkg::*;
#(
    parameter int unsigned       ADDR_W = 8,
    parameter int unsigned       DATA_W = 32,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'('h40)
) (
    input  logic              apb_pclk,
    input  logic              apb_prstn,
    input  logic              apb_psel,
    input  logic [ADDR_W-1:0] apb_paddr,
    input  logic              apb_pwrite,
    input  logic              apb_penable,
    input  logic [DATA_W-1:0] apb_pwdata,
    output logic [DATA_W-1:0] apb_prdata,
    input  logic              pwm_in,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = BASE + ADDR_W'(OFF_CTRL);
    localparam logic [ADDR_W-1:0] ADDR_STAT   = BASE + ADDR_W'(OFF_STAT);
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = BASE + ADDR_W'(OFF_PERIOD);
    localparam logic [ADDR_W-1:0] ADDR_HIGH   = BASE + ADDR_W'(OFF_HIGH);

    cap_state_e        state_q, state_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] high_sh_q, high_sh_d;
    logic [DATA_W-1:0] period_q, period_d;
    logic [DATA_W-1:0] high_q, high_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              en_q, en_d;
    logic              irq_en_q, irq_en_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              irq_q, irq_d;

    logic              rise, fall, level;
    logic              valid_set, ovf_set;
    logic              apb_wr, apb_rd_setup, stat_clr;
    logic [DATA_W-1:0] rdata;
    logic              unused_bits;

    pwm_edge_sync u_sync (
        .clk_i   (apb_pclk),
        .rstn_i  (apb_prstn),
        .in_i    (pwm_in),
        .rise_o  (rise),
        .fall_o  (fall),
        .level_o (level)
    );

    assign unused_bits  = ^{level, apb_pwdata[DATA_W-1:2]};
    assign apb_wr       = apb_psel & apb_penable & apb_pwrite;
    assign apb_rd_setup = apb_psel & ~apb_penable & ~apb_pwrite;
    assign stat_clr     = apb_wr && (apb_paddr == ADDR_STAT);

    // Overflow outranks a coincident rise: a period that hit all-ones is never published.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        high_sh_d = high_sh_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_set = 1'b0;
        ovf_set   = 1'b0;
        if (!en_q) begin
            state_d   = IDLE;
            cnt_d     = '0;
            high_sh_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = DATA_W'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    cnt_d = cnt_q + DATA_W'(1);
                    if (&cnt_q) begin
                        ovf_set = 1'b1;
                        cnt_d   = '0;
                        state_d = ARM;
                    end else if (rise) begin
                        period_d  = cnt_q;
                        high_d    = high_sh_q;
                        valid_set = 1'b1;
                        cnt_d     = DATA_W'(1);
                    end else if (fall) begin
                        high_sh_d = cnt_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (apb_paddr)
            ADDR_CTRL: begin
                rdata[CTRL_EN]     = en_q;
                rdata[CTRL_IRQ_EN] = irq_en_q;
            end
            ADDR_STAT: begin
                rdata[STAT_VALID] = valid_q;
                rdata[STAT_OVF]   = ovf_q;
            end
            ADDR_PERIOD: rdata = period_q;
            ADDR_HIGH:   rdata = high_q;
            default:     rdata = '0;
        endcase
    end

    // Hardware set wins over a same-cycle write-1-to-clear.
    always_comb begin
        en_d     = en_q;
        irq_en_d = irq_en_q;
        if (apb_wr && (apb_paddr == ADDR_CTRL)) begin
            en_d     = apb_pwdata[CTRL_EN];
            irq_en_d = apb_pwdata[CTRL_IRQ_EN];
        end
        valid_d  = (valid_q & ~(stat_clr & apb_pwdata[STAT_VALID])) | valid_set;
        ovf_d    = (ovf_q & ~(stat_clr & apb_pwdata[STAT_OVF])) | ovf_set;
        irq_d    = irq_en_q & (valid_q | ovf_q);
        prdata_d = apb_rd_setup ? rdata : prdata_q;
    end

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            high_sh_q <= '0;
            period_q  <= '0;
            high_q    <= '0;
            prdata_q  <= '0;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            high_sh_q <= high_sh_d;
            period_q  <= period_d;
            high_q    <= high_d;
            prdata_q  <= prdata_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
        end
    end

    assign apb_prdata = prdata_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_apb_pwm_capture.sv
// tb/tb_apb_pwm_capture.sv - self-checking bench for apb_pwm_capture
module tb_apb_pwm_capture;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam logic [7:0] A_CTRL = 8'h40;
    localparam logic [7:0] A_STAT = 8'h44;
    localparam logic [7:0] A_PER  = 8'h48;
    localparam logic [7:0] A_HIGH = 8'h4C;
    localparam logic [7:0] A_UNM  = 8'h50;
    localparam int CNT_MAX = (1 << DW) - 1;

    logic          clk;
    logic          rst_n;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pwm_in;
    logic          irq;

    apb_pwm_capture #(.ADDR_W(AW), .DATA_W(DW), .BASE(8'h40)) dut (
        .apb_pclk    (clk),
        .apb_prstn   (rst_n),
        .apb_psel    (psel),
        .apb_paddr   (paddr),
        .apb_pwrite  (pwrite),
        .apb_penable (penable),
        .apb_pwdata  (pwdata),
        .apb_prdata  (prdata),
        .pwm_in      (pwm_in),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: timestamps of synchronised edges, not a counter.
    int  cyc = 0;
    int  mode;
    int  r_cyc, f_cyc;
    int  m_period, m_high, m_prdata;
    bit  m_en, m_ien, m_valid, m_ovf, m_irq;
    bit  h1, h2, h3;
    bit  m_rise, m_fall, m_vset, m_oset, m_sclr;

    function automatic int reg_val(input logic [7:0] a);
        case (a)
            A_CTRL:  return {m_ien, m_en};
            A_STAT:  return {m_ovf, m_valid};
            A_PER:   return m_period;
            A_HIGH:  return m_high;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode = 0; r_cyc = 0; f_cyc = 0;
            m_period = 0; m_high = 0; m_prdata = 0;
            m_en = 0; m_ien = 0; m_valid = 0; m_ovf = 0; m_irq = 0;
            h1 = 0; h2 = 0; h3 = 0;
        end else begin
            cyc = cyc + 1;
            m_rise = h2 && !h3;
            m_fall = !h2 && h3;
            if (psel && !penable && !pwrite) m_prdata = reg_val(paddr);
            m_irq  = m_ien && (m_valid || m_ovf);
            m_vset = 0;
            m_oset = 0;
            if (!m_en) mode = 0;
            else if (mode == 0) mode = 1;
            else if (mode == 1) begin
                if (m_rise) begin r_cyc = cyc; mode = 2; end
            end else begin
                if (cyc - r_cyc == CNT_MAX) begin
                    m_oset = 1; mode = 1;
                end else if (m_rise) begin
                    m_period = cyc - r_cyc;
                    m_high   = f_cyc - r_cyc;
                    m_vset   = 1;
                    r_cyc    = cyc;
                end else if (m_fall) f_cyc = cyc;
            end
            m_sclr = psel && penable && pwrite && (paddr == A_STAT);
            if (psel && penable && pwrite && (paddr == A_CTRL)) begin
                m_en  = pwdata[0];
                m_ien = pwdata[1];
            end
            m_valid = (m_valid && !(m_sclr && pwdata[0])) || m_vset;
            m_ovf   = (m_ovf && !(m_sclr && pwdata[1])) || m_oset;
            h3 = h2; h2 = h1; h1 = pwm_in;
        end
    end

    always @(posedge clk) begin
        #3;
        if (cmp_on) begin
            chk("prdata", int'(prdata), m_prdata);
            chk("irq", int'(irq), int'(m_irq));
        end
    end

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk); psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(negedge clk); penable = 1;
        @(negedge clk); psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [7:0] a, output int d);
        @(negedge clk); psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(negedge clk); penable = 1; d = int'(prdata);
        @(negedge clk); psel = 0; penable = 0;
    endtask

    task automatic read_chk(input string name, input logic [7:0] a, input int exp);
        int v;
        apb_read(a, v);
        chk(name, v, exp);
    endtask

    task automatic pwm_for(input logic v, input int n);
        @(negedge clk); pwm_in = v;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    logic [7:0] addrs [6] = '{8'h40, 8'h44, 8'h48, 8'h4C, 8'h50, 8'h3C};
    logic [7:0] ctrls [6] = '{8'h3, 8'h3, 8'h3, 8'h1, 8'h2, 8'h0};
    bit done;

    initial begin
        int v;
        rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pwm_in = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        cmp_on = 1;
        chk("reset_prdata", int'(prdata), 0);
        chk("reset_irq", int'(irq), 0);
        read_chk("reset_stat", A_STAT, 0);

        // 100/30 waveform: first rise arms, second captures
        apb_write(A_CTRL, 8'h3);
        pwm_for(0, 5);
        pwm_for(1, 30); pwm_for(0, 70);
        pwm_for(1, 30);
        fork
            pwm_for(0, 70);
            begin
                repeat (2) @(negedge clk);
                read_chk("period_100", A_PER, 100);
                read_chk("high_30", A_HIGH, 30);
                read_chk("stat_valid", A_STAT, 1);
                chk("irq_set", int'(irq), 1);
                apb_write(A_STAT, 8'h1);
                @(negedge clk);
                chk("irq_cleared", int'(irq), 0);
                read_chk("stat_cleared", A_STAT, 0);
            end
        join
        pwm_for(1, 30);
        fork
            pwm_for(0, 70);
            begin
                repeat (2) @(negedge clk);
                read_chk("stat_revalid", A_STAT, 1);
                read_chk("period_again", A_PER, 100);
            end
        join

        // held high past the counter limit
        pwm_for(1, 300);
        fork
            pwm_for(0, 20);
            begin
                read_chk("stat_ovf", A_STAT, 3);
                read_chk("period_kept", A_PER, 100);
                read_chk("high_kept", A_HIGH, 30);
            end
        join
        pwm_for(1, 20); pwm_for(0, 30);
        pwm_for(1, 20);
        fork
            pwm_for(0, 30);
            begin
                read_chk("period_50", A_PER, 50);
                read_chk("high_20", A_HIGH, 20);
            end
        join

        // disable mid-period, then re-enable
        pwm_for(1, 20);
        fork pwm_for(0, 30); apb_write(A_CTRL, 8'h2); join
        pwm_for(1, 20);
        fork
            pwm_for(0, 40);
            begin
                read_chk("period_retained", A_PER, 50);
                apb_write(A_CTRL, 8'h3);
            end
        join
        pwm_for(1, 25);
        fork pwm_for(0, 45); read_chk("arm_no_capture", A_PER, 50); join
        pwm_for(1, 25);
        fork
            pwm_for(0, 45);
            begin
                read_chk("period_70", A_PER, 70);
                read_chk("high_25", A_HIGH, 25);
            end
        join

        // W1C landing on the capture edge
        @(negedge clk); pwm_in = 1;
        apb_write(A_STAT, 8'h3);
        pwm_for(1, 21);
        fork pwm_for(0, 55); read_chk("w1c_set_wins", A_STAT, 1); join

        // read issued on the capture edge sees the old period
        @(negedge clk); pwm_in = 1;
        @(negedge clk);
        apb_read(A_PER, v);
        chk("read_pre_update", v, 70);
        pwm_for(1, 20);
        fork
            pwm_for(0, 55);
            begin
                read_chk("period_80", A_PER, 80);
                read_chk("high_25b", A_HIGH, 25);
            end
        join

        // randomized waveform with concurrent register traffic
        done = 0;
        fork
            begin
                for (int i = 0; i < 14; i++) begin
                    int per, hi;
                    per = int'($urandom_range(20, 150));
                    hi  = int'($urandom_range(1, per - 1));
                    pwm_for(1, hi);
                    pwm_for(0, per - hi);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    case ($urandom_range(0, 3))
                        0: apb_write(A_STAT, 8'($urandom_range(0, 3)));
                        1: apb_write(A_CTRL, ctrls[$urandom_range(0, 5)]);
                        default: apb_read(addrs[$urandom_range(0, 5)], v);
                    endcase
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                end
            end
        join

        // reset in the middle of a measurement
        apb_write(A_CTRL, 8'h3);
        pwm_for(1, 20); pwm_for(0, 30);
        pwm_for(1, 20); pwm_for(0, 10);
        chk("irq_before_reset", int'(irq), 1);
        read_chk("period_before_reset", A_PER, 50);
        @(negedge clk); rst_n = 0;
        #1;
        chk("reset_async_irq", int'(irq), 0);
        chk("reset_async_prdata", int'(prdata), 0);
        @(negedge clk); rst_n = 1;
        read_chk("post_reset_ctrl", A_CTRL, 0);
        read_chk("post_reset_stat", A_STAT, 0);
        read_chk("post_reset_period", A_PER, 0);
        apb_write(A_CTRL, 8'h3);
        pwm_for(0, 5);
        pwm_for(1, 15); pwm_for(0, 25);
        pwm_for(1, 15); pwm_for(0, 25);
        read_chk("period_40", A_PER, 40);
        read_chk("high_15", A_HIGH, 15);
        read_chk("unmapped_50", A_UNM, 0);
        read_chk("unmapped_3c", 8'h3C, 0);

        repeat (5) @(negedge clk);
        cmp_on = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
